// File: rtl/irq_pkg.sv
// Shared types and default sizing for the external interrupt controller.
package irq_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQUEST = 2'd1,
      SERVICE = 2'd2
   } irqState_e;

   localparam int IRQ_NSRC        = 4;
   localparam int IRQ_ACK_TIMEOUT = 64;

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser per line plus a history flop; flags a rising edge
// for one cycle once the line is safely in the clock domain.
module irq_sync_edge #(
   parameter int WIDTH = 4
) (
   input  logic             CLOCK_50,
   input  logic             reset,
   input  logic [WIDTH-1:0] async_in,
   output logic [WIDTH-1:0] edge_out
);

   logic [WIDTH-1:0] sync1_r;
   logic [WIDTH-1:0] sync2_r;
   logic [WIDTH-1:0] hist_r;

   // Synchroniser chain and edge-history register.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         sync1_r <= '0;
         sync2_r <= '0;
         hist_r  <= '0;
      end else begin
         sync1_r <= async_in;
         sync2_r <= sync1_r;
         hist_r  <= sync2_r;
      end
   end

   assign edge_out = sync2_r & ~hist_r;

endmodule

// File: rtl/irq_controller.sv
// External interrupt controller: latches source edges into pending, masks,
// picks the lowest eligible index and hands it to the processor via ExtIRQ.
module irq_controller
   import irq_pkg::*;
#(
   parameter int NSRC        = IRQ_NSRC,
   parameter int ACK_TIMEOUT = IRQ_ACK_TIMEOUT
) (
   input  logic                    CLOCK_50,
   input  logic                    reset,
   input  logic [NSRC-1:0]         irq_src,
   input  logic                    mask_we,
   input  logic [NSRC-1:0]         mask_wdata,
   input  logic                    ExtIAck,
   input  logic                    eret,
   output logic                    ExtIRQ,
   output logic [$clog2(NSRC)-1:0] irq_cause,
   output logic                    irq_active,
   output logic [NSRC-1:0]         irq_mask,
   output logic [NSRC-1:0]         pending,
   output logic [NSRC-1:0]         overflow,
   output logic                    ack_timeout
);

   localparam int IDXW = $clog2(NSRC);
   localparam int CNTW = $clog2(ACK_TIMEOUT);
   localparam logic [CNTW-1:0] CNT_MAX = CNTW'(ACK_TIMEOUT - 1);
   localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
   localparam logic [NSRC-1:0] SRC_ONE = NSRC'(1);

   irqState_e       state_r;
   irqState_e       stateNext_s;
   logic [CNTW-1:0] cnt_r;
   logic [CNTW-1:0] cntNext_s;
   logic            extIrqNext_s;
   logic [IDXW-1:0] causeNext_s;
   logic            activeNext_s;
   logic            ackTimeoutNext_s;
   logic [NSRC-1:0] maskNext_s;
   logic [NSRC-1:0] pendingNext_s;
   logic [NSRC-1:0] overflowNext_s;
   logic [NSRC-1:0] edge_s;
   logic [NSRC-1:0] eligible_s;
   logic [NSRC-1:0] lowestBit_s;
   logic [IDXW-1:0] winner_s;
   logic            anyEligible_s;
   logic [NSRC-1:0] clrVec_s;
   logic [NSRC-1:0] setVec_s;

   irq_sync_edge #(
      .WIDTH (NSRC)
   ) uSyncEdge (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .async_in (irq_src),
      .edge_out (edge_s)
   );

   // Fixed-priority encoder: lowest eligible index wins.
   always_comb begin
      eligible_s    = pending & ~irq_mask;
      anyEligible_s = |eligible_s;
      lowestBit_s   = eligible_s & (~eligible_s + SRC_ONE);
      winner_s      = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (eligible_s[i]) begin
            winner_s = IDXW'(i);
         end else begin
            winner_s = winner_s;
         end
      end
   end

   // Next-state and next-output logic for the request handshake.
   always_comb begin
      stateNext_s      = state_r;
      cntNext_s        = cnt_r;
      extIrqNext_s     = ExtIRQ;
      causeNext_s      = irq_cause;
      activeNext_s     = irq_active;
      ackTimeoutNext_s = 1'b0;
      clrVec_s         = '0;
      setVec_s         = '0;
      case (state_r)
         IDLE: begin
            if (anyEligible_s) begin
               clrVec_s     = lowestBit_s;
               causeNext_s  = winner_s;
               extIrqNext_s = 1'b1;
               activeNext_s = 1'b1;
               cntNext_s    = '0;
               stateNext_s  = REQUEST;
            end else begin
               extIrqNext_s = 1'b0;
               activeNext_s = 1'b0;
            end
         end
         REQUEST: begin
            // Ack takes precedence over a timeout landing in the same cycle.
            if (ExtIAck) begin
               extIrqNext_s = 1'b0;
               stateNext_s  = SERVICE;
            end else if (cnt_r == CNT_MAX) begin
               extIrqNext_s          = 1'b0;
               activeNext_s          = 1'b0;
               setVec_s[irq_cause]   = 1'b1;
               ackTimeoutNext_s      = 1'b1;
               stateNext_s           = IDLE;
            end else begin
               cntNext_s = cnt_r + CNT_ONE;
            end
         end
         SERVICE: begin
            extIrqNext_s = 1'b0;
            if (eret) begin
               activeNext_s = 1'b0;
               stateNext_s  = IDLE;
            end else begin
               activeNext_s = 1'b1;
            end
         end
         default: begin
            extIrqNext_s = 1'b0;
            activeNext_s = 1'b0;
            stateNext_s  = IDLE;
         end
      endcase
   end

   // A fresh edge beats the IDLE clear, so it neither drops nor overflows.
   always_comb begin
      maskNext_s     = mask_we ? mask_wdata : irq_mask;
      pendingNext_s  = (pending & ~clrVec_s) | edge_s | setVec_s;
      overflowNext_s = overflow | (edge_s & pending & ~clrVec_s);
   end

   // State, counter and all registered outputs.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_r     <= IDLE;
         cnt_r       <= '0;
         ExtIRQ      <= 1'b0;
         irq_cause   <= '0;
         irq_active  <= 1'b0;
         irq_mask    <= '1;
         pending     <= '0;
         overflow    <= '0;
         ack_timeout <= 1'b0;
      end else begin
         state_r     <= stateNext_s;
         cnt_r       <= cntNext_s;
         ExtIRQ      <= extIrqNext_s;
         irq_cause   <= causeNext_s;
         irq_active  <= activeNext_s;
         irq_mask    <= maskNext_s;
         pending     <= pendingNext_s;
         overflow    <= overflowNext_s;
         ack_timeout <= ackTimeoutNext_s;
      end
   end

endmodule
